alarm_controller: RTL and testbench

- Car-alarm sequencer; drives the `enable` input of the siren tone generator and the dashboard status LED.
- Upstream, inputs arrive already synchronised and debounced, plus a one-cycle `one_hz_enable` tick from the divider.
- Implements arm/trigger/sound/disarm sequencing with a programmable countdown timer, plus a fuel-pump interlock.

---
 rtl/alarm_controller_pkg.sv | 27 ++
 rtl/alarm_timer.sv | 31 +++
 rtl/alarm_controller.sv | 141 ++++++++++++++
 tb/tb_alarm_controller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the car-alarm sequencer: state encodings, timer width
// and the default countdown lengths (in seconds).
package alarm_controller_pkg;

    localparam int TW = 4;

    localparam int DEF_T_ARM_DELAY       = 6;
    localparam int DEF_T_DRIVER_DELAY    = 8;
    localparam int DEF_T_PASSENGER_DELAY = 15;
    localparam int DEF_T_ALARM_ON        = 10;

    typedef enum logic [2:0] {
        ST_ARMED     = 3'd0,
        ST_TRIGGERED = 3'd1,
        ST_SOUND     = 3'd2,
        ST_DISARMED  = 3'd3,
        ST_IGN_OFF   = 3'd4,
        ST_DOOR_OPEN = 3'd5,
        ST_ARMING    = 3'd6
    } alarm_state_t;

    // States in which the countdown timer is running.
    function automatic logic is_timed(alarm_state_t s);
        return (s == ST_TRIGGERED) || (s == ST_SOUND) || (s == ST_ARMING);
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// Seconds countdown used by the alarm sequencer. A load of N expires on the
// Nth tick after the load; a load in the same cycle as a tick wins.
module alarm_timer
    import alarm_controller_pkg::*;
#(
    parameter int W = TW
) (
    input  logic         clock_25mhz,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         tick,
    output logic         expired,
    output logic [W-1:0] value
);

    // Expiry is the tick that consumes the last remaining second.
    assign expired = tick && (value == W'(1));

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (tick && (value != '0)) begin
            value <= value - W'(1);
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Car-alarm sequencer: arm / trigger / sound / disarm with a seconds timer,
// plus a fuel-pump interlock latch that is independent of the alarm state.
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int T_ARM_DELAY       = DEF_T_ARM_DELAY,
    parameter int T_DRIVER_DELAY    = DEF_T_DRIVER_DELAY,
    parameter int T_PASSENGER_DELAY = DEF_T_PASSENGER_DELAY,
    parameter int T_ALARM_ON        = DEF_T_ALARM_ON
) (
    input  logic       clock_25mhz,
    input  logic       reset,
    input  logic       one_hz_enable,
    input  logic       ignition,
    input  logic       driver_door,
    input  logic       passenger_door,
    input  logic       hidden_switch,
    input  logic       brake_pedal,
    output logic       siren_enable,
    output logic       status_led,
    output logic       fuel_pump_power,
    output logic [2:0] state_out
);

    alarm_state_t  state;
    alarm_state_t  next_state;
    logic          timer_load;
    logic [TW-1:0] timer_load_value;
    logic [TW-1:0] timer_value;
    logic          timer_expired;
    logic          any_door;

    assign any_door  = driver_door | passenger_door;
    assign state_out = state;

    alarm_timer #(.W(TW)) u_timer (
        .clock_25mhz (clock_25mhz),
        .reset       (reset),
        .load        (timer_load),
        .load_value  (timer_load_value),
        .tick        (one_hz_enable),
        .expired     (timer_expired),
        .value       (timer_value)
    );

    // Next-state and timer-load decisions: ignition first, then doors, then expiry.
    always_comb begin
        next_state       = state;
        timer_load       = 1'b0;
        timer_load_value = '0;
        if (ignition) begin
            next_state = ST_DISARMED;
        end else begin
            case (state)
                ST_ARMED: begin
                    // Both doors in one cycle take the (shorter) driver grace.
                    if (driver_door) begin
                        next_state       = ST_TRIGGERED;
                        timer_load       = 1'b1;
                        timer_load_value = TW'(T_DRIVER_DELAY);
                    end else if (passenger_door) begin
                        next_state       = ST_TRIGGERED;
                        timer_load       = 1'b1;
                        timer_load_value = TW'(T_PASSENGER_DELAY);
                    end
                end
                ST_TRIGGERED: begin
                    if (timer_expired) begin
                        next_state       = ST_SOUND;
                        timer_load       = 1'b1;
                        timer_load_value = TW'(T_ALARM_ON);
                    end
                end
                ST_SOUND: begin
                    // An open door keeps the siren window topped up.
                    if (any_door) begin
                        timer_load       = 1'b1;
                        timer_load_value = TW'(T_ALARM_ON);
                    end else if (timer_expired) begin
                        next_state = ST_ARMED;
                    end
                end
                ST_DISARMED:  next_state = ST_IGN_OFF;
                ST_IGN_OFF: begin
                    if (driver_door) next_state = ST_DOOR_OPEN;
                end
                ST_DOOR_OPEN: begin
                    if (!driver_door) begin
                        next_state       = ST_ARMING;
                        timer_load       = 1'b1;
                        timer_load_value = TW'(T_ARM_DELAY);
                    end
                end
                ST_ARMING: begin
                    if (driver_door) begin
                        next_state = ST_DOOR_OPEN;
                    end else if (timer_expired) begin
                        next_state = ST_ARMED;
                    end
                end
                default: next_state = ST_ARMED;
            endcase
        end
        // Any leftover count is cleared when landing in an untimed state.
        if (!is_timed(next_state) && (timer_value != '0)) begin
            timer_load       = 1'b1;
            timer_load_value = '0;
        end
    end

    // State register with registered siren and LED derived from the next state.
    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            state        <= ST_ARMED;
            siren_enable <= 1'b0;
            status_led   <= 1'b0;
        end else begin
            state        <= next_state;
            siren_enable <= (next_state == ST_SOUND);
            case (next_state)
                // Blink while resting in ARMED; entering ARMED starts dark.
                ST_ARMED:               status_led <= (state == ST_ARMED) ?
                                                      (status_led ^ one_hz_enable) : 1'b0;
                ST_TRIGGERED, ST_SOUND: status_led <= 1'b1;
                default:                status_led <= 1'b0;
            endcase
        end
    end

    // Fuel-pump latch: set by key + hidden switch + brake, cleared by key off.
    always_ff @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            fuel_pump_power <= 1'b0;
        end else if (!ignition) begin
            fuel_pump_power <= 1'b0;
        end else if (hidden_switch && brake_pedal) begin
            fuel_pump_power <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios with literal expectations
// followed by randomized driving, all checked against a behavioural model.
module tb_alarm_controller;

    localparam int P_ARM   = 2;
    localparam int P_DRV   = 3;
    localparam int P_PAS   = 4;
    localparam int P_ALARM = 3;

    localparam int S_ARMED  = 0;
    localparam int S_TRIG   = 1;
    localparam int S_SOUND  = 2;
    localparam int S_DIS    = 3;
    localparam int S_IGNOFF = 4;
    localparam int S_DOOR   = 5;
    localparam int S_ARMING = 6;

    logic       clock_25mhz    = 1'b0;
    logic       reset          = 1'b1;
    logic       one_hz_enable  = 1'b0;
    logic       ignition       = 1'b0;
    logic       driver_door    = 1'b0;
    logic       passenger_door = 1'b0;
    logic       hidden_switch  = 1'b0;
    logic       brake_pedal    = 1'b0;
    logic       siren_enable;
    logic       status_led;
    logic       fuel_pump_power;
    logic [2:0] state_out;

    int n_cmp = 0;
    int n_err = 0;
    bit checker_on = 1'b0;
    int tick_phase = 0;

    // Behavioural model: state, seconds remaining on the countdown, outputs.
    int m_state = S_ARMED;
    int m_left  = 0;
    bit m_led   = 1'b0;
    bit m_siren = 1'b0;
    bit m_pump  = 1'b0;

    alarm_controller #(
        .T_ARM_DELAY       (P_ARM),
        .T_DRIVER_DELAY    (P_DRV),
        .T_PASSENGER_DELAY (P_PAS),
        .T_ALARM_ON        (P_ALARM)
    ) dut (
        .clock_25mhz     (clock_25mhz),
        .reset           (reset),
        .one_hz_enable   (one_hz_enable),
        .ignition        (ignition),
        .driver_door     (driver_door),
        .passenger_door  (passenger_door),
        .hidden_switch   (hidden_switch),
        .brake_pedal     (brake_pedal),
        .siren_enable    (siren_enable),
        .status_led      (status_led),
        .fuel_pump_power (fuel_pump_power),
        .state_out       (state_out)
    );

    // Clock / reset block: 10 ns clock, one-second tick every 4 clocks.
    always #5 clock_25mhz = ~clock_25mhz;

    always @(negedge clock_25mhz) begin
        tick_phase    = (tick_phase + 1) % 4;
        one_hz_enable = (tick_phase == 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One clock of the alarm rules, written in terms of seconds remaining.
    task automatic model_step();
        int nxt;
        bit last_second;
        last_second = one_hz_enable && (m_left == 1);
        if (one_hz_enable && m_left > 0) m_left--;
        nxt = m_state;
        if (ignition) begin
            nxt = S_DIS;
        end else begin
            case (m_state)
                S_ARMED: begin
                    if (driver_door)         begin nxt = S_TRIG; m_left = P_DRV; end
                    else if (passenger_door) begin nxt = S_TRIG; m_left = P_PAS; end
                end
                S_TRIG:   if (last_second) begin nxt = S_SOUND; m_left = P_ALARM; end
                S_SOUND: begin
                    if (driver_door || passenger_door) m_left = P_ALARM;
                    else if (last_second)              nxt = S_ARMED;
                end
                S_DIS:    nxt = S_IGNOFF;
                S_IGNOFF: if (driver_door) nxt = S_DOOR;
                S_DOOR:   if (!driver_door) begin nxt = S_ARMING; m_left = P_ARM; end
                S_ARMING: begin
                    if (driver_door)      nxt = S_DOOR;
                    else if (last_second) nxt = S_ARMED;
                end
                default:  nxt = S_ARMED;
            endcase
        end
        if (!(nxt inside {S_TRIG, S_SOUND, S_ARMING})) m_left = 0;
        if (nxt == S_ARMED) m_led = (m_state == S_ARMED) ? (m_led ^ one_hz_enable) : 1'b0;
        else                m_led = (nxt == S_TRIG) || (nxt == S_SOUND);
        m_siren = (nxt == S_SOUND);
        if (!ignition)                        m_pump = 1'b0;
        else if (hidden_switch && brake_pedal) m_pump = 1'b1;
        m_state = nxt;
    endtask

    always @(posedge clock_25mhz or posedge reset) begin
        if (reset) begin
            m_state = S_ARMED;
            m_left  = 0;
            m_led   = 1'b0;
            m_siren = 1'b0;
            m_pump  = 1'b0;
        end else begin
            model_step();
        end
    end

    // Scoreboard compare: every falling edge outside reset.
    always @(negedge clock_25mhz) begin
        if (checker_on && !reset) begin
            check("model_state", state_out, m_state);
            check("model_siren", siren_enable, m_siren);
            check("model_led", status_led, m_led);
            check("model_pump", fuel_pump_power, m_pump);
        end
    end

    // Driver tasks.
    task automatic settle();
        @(posedge clock_25mhz);
        #1;
    endtask

    task automatic wait_ticks(input int n, input string name);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < 200) begin
            @(posedge clock_25mhz);
            budget++;
            if (one_hz_enable) seen++;
        end
        #1;
        if (seen < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: tick wait timed out, saw %0d of %0d ticks", name, seen, n);
        end
    endtask

    initial begin
        // Reset values.
        repeat (3) @(posedge clock_25mhz);
        #1;
        check("reset_state", state_out, S_ARMED);
        check("reset_siren", siren_enable, 0);
        check("reset_led", status_led, 0);
        check("reset_pump", fuel_pump_power, 0);
        @(negedge clock_25mhz);
        reset = 1'b0;
        checker_on = 1'b1;

        // Driver door trigger: 3 ticks to SOUND, 3 ticks after closing to ARMED.
        @(negedge clock_25mhz); driver_door = 1'b1;
        settle();
        check("drv_trig_state", state_out, S_TRIG);
        check("drv_trig_led", status_led, 1);
        wait_ticks(2, "drv_grace");
        check("drv_before_expiry", state_out, S_TRIG);
        wait_ticks(1, "drv_grace_end");
        check("drv_sound_state", state_out, S_SOUND);
        check("drv_sound_siren", siren_enable, 1);
        @(negedge clock_25mhz); driver_door = 1'b0;
        wait_ticks(2, "drv_alarm");
        check("drv_still_sound", state_out, S_SOUND);
        wait_ticks(1, "drv_alarm_end");
        check("drv_rearmed_state", state_out, S_ARMED);
        check("drv_rearmed_siren", siren_enable, 0);

        // Both doors together: driver delay, siren held while doors open.
        @(negedge clock_25mhz); driver_door = 1'b1; passenger_door = 1'b1;
        settle();
        check("both_trig_state", state_out, S_TRIG);
        wait_ticks(2, "both_grace");
        check("both_before_expiry", state_out, S_TRIG);
        wait_ticks(1, "both_grace_end");
        check("both_driver_delay", state_out, S_SOUND);
        wait_ticks(10, "both_held");
        check("held_open_state", state_out, S_SOUND);
        check("held_open_siren", siren_enable, 1);
        @(negedge clock_25mhz); driver_door = 1'b0; passenger_door = 1'b0;
        wait_ticks(2, "both_alarm");
        check("both_still_sound", state_out, S_SOUND);
        wait_ticks(1, "both_alarm_end");
        check("both_rearmed", state_out, S_ARMED);

        // Asynchronous reset in the middle of SOUND.
        @(negedge clock_25mhz); driver_door = 1'b1;
        settle();
        wait_ticks(3, "pre_reset");
        check("pre_reset_siren", siren_enable, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_siren", siren_enable, 0);
        check("async_reset_led", status_led, 0);
        check("async_reset_state", state_out, S_ARMED);
        check("async_reset_pump", fuel_pump_power, 0);
        driver_door = 1'b0;
        repeat (2) @(posedge clock_25mhz);
        @(negedge clock_25mhz); reset = 1'b0;

        // Disarm from TRIGGERED, then the door open/close re-arm path.
        @(negedge clock_25mhz); driver_door = 1'b1;
        settle();
        check("dis_trig", state_out, S_TRIG);
        @(negedge clock_25mhz); driver_door = 1'b0; ignition = 1'b1;
        settle();
        check("disarmed_state", state_out, S_DIS);
        check("disarmed_siren", siren_enable, 0);
        @(negedge clock_25mhz); ignition = 1'b0;
        settle();
        check("ign_off_state", state_out, S_IGNOFF);
        @(negedge clock_25mhz); driver_door = 1'b1;
        settle();
        check("door_open_state", state_out, S_DOOR);
        @(negedge clock_25mhz); driver_door = 1'b0;
        settle();
        check("arming_state", state_out, S_ARMING);
        wait_ticks(1, "arming_first");
        check("arming_tick1", state_out, S_ARMING);
        @(negedge clock_25mhz); driver_door = 1'b1;
        settle();
        check("reopen_in_arming", state_out, S_DOOR);
        @(negedge clock_25mhz); driver_door = 1'b0;
        settle();
        check("rearming_state", state_out, S_ARMING);
        wait_ticks(1, "rearm_1");
        check("rearm_after_1", state_out, S_ARMING);
        wait_ticks(1, "rearm_2");
        check("rearm_complete", state_out, S_ARMED);
        check("rearm_led_dark", status_led, 0);

        // ARMED blink: LED toggles on each tick starting from dark.
        for (int k = 1; k <= 6; k++) begin
            wait_ticks(1, "blink");
            check("blink_led", status_led, k % 2);
        end

        // Fuel-pump interlock.
        @(negedge clock_25mhz); ignition = 1'b1; hidden_switch = 1'b1;
        settle();
        check("pump_no_brake", fuel_pump_power, 0);
        @(negedge clock_25mhz); brake_pedal = 1'b1;
        settle();
        check("pump_set", fuel_pump_power, 1);
        @(negedge clock_25mhz); brake_pedal = 1'b0; hidden_switch = 1'b0;
        settle();
        check("pump_hold", fuel_pump_power, 1);
        @(negedge clock_25mhz); ignition = 1'b0;
        settle();
        check("pump_cleared", fuel_pump_power, 0);
        check("pump_ign_off_state", state_out, S_IGNOFF);

        // Randomized driving, checked every cycle by the scoreboard.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock_25mhz);
            if ($urandom_range(0, 11) == 0) driver_door    = ~driver_door;
            if ($urandom_range(0, 15) == 0) passenger_door = ~passenger_door;
            if ($urandom_range(0, 59) == 0) ignition       = ~ignition;
            hidden_switch = ($urandom_range(0, 3) == 0);
            brake_pedal   = ($urandom_range(0, 3) == 0);
        end

        @(negedge clock_25mhz);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
